// File: rtl/cnn_pkg.sv
// Shared CNN accelerator definitions: PE controller state
// encoding and default filter geometry.
package cnn_pkg;

  localparam int FILT_LEN_DEF = 16;
  localparam int WORDS_DEF    = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LOAD,
    WAITW,
    MAC,
    WRITE,
    NEXT,
    FIN
  } peState_t;

endpackage

// File: rtl/pe_ctrl.sv
// PE controller: loads one filter into the PE buffer, then runs
// one MAC burst plus OFM write per window, num_out times.
module pe_ctrl
  import cnn_pkg::*;
#(
  parameter int FILT_LEN = FILT_LEN_DEF,
  parameter int WORDS    = WORDS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] filt_base,
  input  logic [7:0] num_out,
  input  logic       win_valid,
  output logic       memRdEn,
  output logic [7:0] memAddr,
  output logic       winRst,
  output logic       wEnFilter,
  output logic       readEnmac,
  output logic       addEn,
  output logic [5:0] filterCount,
  output logic [5:0] macCount,
  output logic       wrofm,
  output logic [7:0] ofmaddr,
  output logic       winReq,
  output logic       busy,
  output logic       done
);

  localparam logic [5:0] LastLd  = 6'(WORDS);
  localparam logic [5:0] LastMac = 6'(FILT_LEN - 1);

  peState_t   st, stN;
  logic [5:0] cnt, cntN;
  logic [7:0] baseQ, baseN;
  logic [7:0] numQ, numN;
  logic [7:0] ofmN;
  logic [8:0] outQ, outN;

  logic       rdN, winRstN, wEnN, macN;
  logic       wrN, reqN, busyN, doneN;
  logic [7:0] addrN;
  logic [5:0] fcN, mcN;

  always_comb begin
    stN   = st;
    cntN  = cnt;
    baseN = baseQ;
    numN  = numQ;
    ofmN  = ofmaddr;
    outN  = outQ;
    unique case (st)
      IDLE: begin
        if (start) begin
          stN   = CLR;
          baseN = filt_base;
          numN  = num_out;
          ofmN  = '0;
          outN  = '0;
        end
      end
      CLR: begin
        stN  = LOAD;
        cntN = '0;
      end
      // one extra LOAD cycle absorbs the read latency of the last word
      LOAD: begin
        if (cnt == LastLd) begin
          stN  = (numQ == 8'd0) ? FIN : WAITW;
          cntN = '0;
        end else begin
          cntN = cnt + 6'd1;
        end
      end
      WAITW: begin
        if (win_valid) begin
          stN  = MAC;
          cntN = '0;
        end
      end
      MAC: begin
        if (cnt == LastMac) begin
          stN  = WRITE;
          cntN = '0;
        end else begin
          cntN = cnt + 6'd1;
        end
      end
      WRITE: begin
        stN  = NEXT;
        outN = outQ + 9'd1;
      end
      NEXT: begin
        ofmN = ofmaddr + 8'd1;
        stN  = (outQ == {1'b0, numQ}) ? FIN : WAITW;
      end
      FIN: stN = IDLE;
      default: stN = IDLE;
    endcase
  end

  // outputs decoded from the next state so every strobe is a flop
  always_comb begin
    rdN     = (stN == LOAD) && (cntN < LastLd);
    wEnN    = (stN == LOAD) && (cntN != 6'd0);
    macN    = (stN == MAC);
    winRstN = (stN == CLR);
    wrN     = (stN == WRITE);
    reqN    = (stN == NEXT);
    doneN   = (stN == FIN);
    busyN   = (stN != IDLE);
    addrN   = rdN ? baseN + {2'b00, cntN} : memAddr;
    fcN     = '0;
    mcN     = '0;
    if (wEnN) fcN = cntN - 6'd1;
    if (macN) begin
      fcN = cntN;
      mcN = cntN + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= IDLE;
      cnt         <= '0;
      baseQ       <= '0;
      numQ        <= '0;
      outQ        <= '0;
      ofmaddr     <= '0;
      memRdEn     <= 1'b0;
      memAddr     <= '0;
      winRst      <= 1'b0;
      wEnFilter   <= 1'b0;
      readEnmac   <= 1'b0;
      addEn       <= 1'b0;
      filterCount <= '0;
      macCount    <= '0;
      wrofm       <= 1'b0;
      winReq      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      st          <= stN;
      cnt         <= cntN;
      baseQ       <= baseN;
      numQ        <= numN;
      outQ        <= outN;
      ofmaddr     <= ofmN;
      memRdEn     <= rdN;
      memAddr     <= addrN;
      winRst      <= winRstN;
      wEnFilter   <= wEnN;
      readEnmac   <= macN;
      addEn       <= macN;
      filterCount <= fcN;
      macCount    <= mcN;
      wrofm       <= wrN;
      winReq      <= reqN;
      busy        <= busyN;
      done        <= doneN;
    end
  end

endmodule

// File: doc/pe_ctrl.md
PE_CTRL -- requirements
Module: pe_ctrl

Interface
REQ-001 SHALL have parameter FILT_LEN, default 16, filter elements per output pixel (range 1..16).
REQ-002 SHALL have parameter WORDS, default 4, 32-bit memory words per filter (equals ceil(FILT_LEN/4)).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a job; honoured only in IDLE.
REQ-006 SHALL have port filt_base  input  8  memory word address of the first filter word; sampled on accepted start.
REQ-007 SHALL have port num_out  input  8  output pixels to compute; sampled on accepted start; 0 means none.
REQ-008 SHALL have port win_valid  input  1  upstream window buffer holds a valid window.
REQ-009 SHALL have port memRdEn / memAddr  output  1 / 8  filter memory read strobe and word address.
REQ-010 SHALL have port winRst  output  1  clears the PE filter buffer.
REQ-011 SHALL have port wEnFilter  output  1  PE filter buffer write enable.
REQ-012 SHALL have port readEnmac / addEn  output  1 / 1  PE filter read enable and accumulate enable.
REQ-013 SHALL have port filterCount / macCount  output  6 / 6  PE filter buffer address and 1-based MAC index (0 = idle).
REQ-014 SHALL have port wrofm / ofmaddr  output  1 / 8  OFM write strobe and address.
REQ-015 SHALL have port winReq  output  1  one-cycle pulse asking upstream to advance the window.
REQ-016 SHALL have port busy / done  output  1 / 1  job in progress; one-cycle completion pulse.

Function
REQ-017 SHALL implement states IDLE, CLR, LOAD, WAITW, MAC, WRITE, NEXT, FIN.
REQ-018 IDLE: start=1 SHALL latch filt_base and num_out, set ofmaddr=0, go CLR; start outside IDLE SHALL be ignored.
REQ-019 CLR: winRst=1 for exactly one cycle; then LOAD.
REQ-020 LOAD: memRdEn=1 for WORDS consecutive cycles with memAddr=filt_base+0..WORDS-1 (8-bit wrap).
REQ-021 Memory read latency is one cycle: wEnFilter SHALL assert in the cycle after each memRdEn, with filterCount=0..WORDS-1 matching the word.
REQ-022 After the last wEnFilter: num_out=0 goes FIN, else WAITW.
REQ-023 WAITW: hold all strobes low until win_valid=1; then MAC.
REQ-024 MAC: FILT_LEN cycles, readEnmac=addEn=1, filterCount=k, macCount=k+1 for k=0..FILT_LEN-1; win_valid ignored.
REQ-025 WRITE: one cycle after the last MAC cycle; wrofm=1 with current ofmaddr; addEn=0, macCount=0.
REQ-026 NEXT: winReq=1 for one cycle, ofmaddr increments (8-bit wrap); if outputs written == num_out, go FIN, else WAITW.
REQ-027 FIN: done=1 for one cycle, then IDLE; busy=1 in every state except IDLE.
REQ-028 Outside their named states, memRdEn, winRst, wEnFilter, readEnmac, addEn, wrofm, winReq, done SHALL be 0, and filterCount, macCount SHALL be 0.
REQ-029 Output counter SHALL be 9 bits wide so num_out=255 completes without wrap.
REQ-030 Strobe outputs SHALL be registered, free of combinational paths from inputs.

Reset
REQ-031 rst=1 SHALL force IDLE and all outputs to 0, including ofmaddr and memAddr, on the next edge.
REQ-032 rst mid-job SHALL abort without done; the next start SHALL begin a full job from CLR.
REQ-033 rst has priority over start in the same cycle.

Structure
REQ-034 State encoding and FILT_LEN/WORDS defaults SHALL reside in shared package cnn_pkg.
REQ-035 No sub-modules; a single FSM plus load, MAC, output and address counters.

Verification
REQ-036 Reset: rst high 3 cycles mid-MAC -> all outputs 0, busy=0, no done.
REQ-037 start, filt_base=0x10, num_out=2, win_valid=1 -> winRst 1 cycle; memAddr 0x10..0x13; wEnFilter next cycles with filterCount 0..3; two MAC bursts of 16, macCount 1..16; wrofm at ofmaddr 0 and 1; two winReq; done once.
REQ-038 num_out=0 -> CLR, LOAD complete, then done; no readEnmac, wrofm or winReq.
REQ-039 win_valid low 5 cycles before the 2nd window -> controller stays in WAITW, no strobes; MAC begins the cycle after win_valid rises.
REQ-040 start pulsed during MAC -> ignored; job and ofmaddr sequence unchanged.
REQ-041 filt_base=0xFE -> memAddr 0xFE, 0xFF, 0x00, 0x01.
